// File: rtl/uart_pkg.sv
// Shared types and register map for the memory-mapped 8N1 UART peripheral.
package uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam logic [31:0] CTRL_OFS   = 32'd0;
  localparam logic [31:0] DATA_OFS   = 32'd4;
  localparam int          SEND_BIT   = 0;
  localparam int          NEW_RX_BIT = 1;

  // Rounded clock cycles per bit.
  function automatic int calc_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: 2-FF synchronizer, mid-bit sampling FSM, byte output with a
// one-cycle valid pulse on a good stop bit.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DIV = 1042
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       rx_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_valid_o
);

  localparam int            CW      = $clog2(DIV);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] LAST    = CW'(DIV - 1);

  logic            sync1_q, sync2_q, prev_q;
  rx_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;

  // State register; synchronizer and edge-detect flops idle high.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Next-state logic: start bit checked at half a bit, then one sample per bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) begin
          state_d = RX_START;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          state_d = RX_START;
        end
      end
      RX_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          state_d = RX_DATA;
        end
      end
      RX_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
        end else begin
          state_d = RX_STOP;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = RX_IDLE;
      end
    endcase
  end

  // Outputs: valid only at the stop-bit sample with the line high.
  always_comb begin
    rx_byte_o = shift_q;
    if ((state_q == RX_STOP) && (cnt_q == LAST) && sync2_q) begin
      rx_valid_o = 1'b1;
    end else begin
      rx_valid_o = 1'b0;
    end
  end

endmodule

// File: rtl/module_interfaz_uart.sv
// UART peripheral at 0x2020-0x2027: control/status and data registers, 8N1
// transmitter FSM and an instantiated 8N1 receiver core.
module module_interfaz_uart
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 10_000_000,
  parameter int BAUD     = 9600
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wr_data_i,
  output logic [31:0] do_o,
  output logic        tx_o,
  input  logic        rx_i
);

  localparam int            DIV  = calc_div(CLK_FREQ, BAUD);
  localparam int            CW   = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  tx_state_t     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_q, tx_d;
  logic [7:0]    tx_buf_q, rx_buf_q;
  logic          new_rx_q;
  logic [7:0]    rx_byte_s;
  logic          rx_valid_s;
  logic          ctrl_wr_s, data_wr_s, send_req_s, tx_busy_s;
  logic          unused_s;

  assign ctrl_wr_s  = we_i && (addr_i[2] == CTRL_OFS[2]);
  assign data_wr_s  = we_i && (addr_i[2] == DATA_OFS[2]);
  assign send_req_s = ctrl_wr_s && wr_data_i[SEND_BIT];
  assign tx_busy_s  = (tx_state_q != TX_IDLE);
  assign unused_s   = ^{addr_i[31:3], addr_i[1:0], wr_data_i[31:8]};
  assign tx_o       = tx_q;

  uart_rx_core #(.DIV(DIV)) u_rx (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .rx_i       (rx_i),
    .rx_byte_o  (rx_byte_s),
    .rx_valid_o (rx_valid_s)
  );

  // Bus registers; a completing byte beats a same-cycle clear of new_rx.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      tx_buf_q <= 8'd0;
      rx_buf_q <= 8'd0;
      new_rx_q <= 1'b0;
    end else begin
      if (data_wr_s) begin
        tx_buf_q <= wr_data_i[7:0];
      end
      if (rx_valid_s) begin
        rx_buf_q <= rx_byte_s;
        new_rx_q <= 1'b1;
      end else if (ctrl_wr_s && !wr_data_i[NEW_RX_BIT]) begin
        new_rx_q <= 1'b0;
      end
    end
  end

  // TX state register with a registered line output.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'd0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  // TX next state; a send arriving on the last stop cycle chains the next frame.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CW'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (send_req_s) begin
          tx_state_d = TX_START;
          tx_shift_d = tx_buf_q;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      TX_START: begin
        if (tx_cnt_q == LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
          tx_state_d = TX_DATA;
        end else begin
          tx_state_d = TX_START;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end else begin
          tx_state_d = TX_DATA;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == LAST) begin
          tx_cnt_d = '0;
          if (send_req_s) begin
            tx_state_d = TX_START;
            tx_shift_d = tx_buf_q;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_state_d = TX_STOP;
        end
      end
      default: begin
        tx_cnt_d   = '0;
        tx_state_d = TX_IDLE;
      end
    endcase
  end

  // TX output: line level for the state being entered.
  always_comb begin
    case (tx_state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = tx_shift_d[tx_bit_d];
      default:  tx_d = 1'b1;
    endcase
  end

  // Read mux.
  always_comb begin
    do_o = 32'd0;
    if (addr_i[2] == DATA_OFS[2]) begin
      do_o[7:0] = rx_buf_q;
    end else begin
      do_o[SEND_BIT]   = tx_busy_s;
      do_o[NEW_RX_BIT] = new_rx_q;
    end
  end

endmodule

// File: tb/tb_module_interfaz_uart.sv
// Randomized bench for module_interfaz_uart with a frame-level reference model
// checked every cycle, plus literal expectations for the directed scenarios.
module tb_module_interfaz_uart;

  localparam int DIV    = 10;
  localparam int RX_LAT = 2 + DIV / 2 + 9 * DIV + 1;
  localparam logic [31:0] A_CTRL = 32'h0000_2020;
  localparam logic [31:0] A_DATA = 32'h0000_2024;

  typedef struct packed {
    logic       lvl;
    logic       ev;
    logic       ok;
    logic [7:0] b;
  } rx_ent_t;

  typedef struct packed {
    int         c;
    logic       ok;
    logic [7:0] b;
  } rx_ev_t;

  logic        clk = 1'b0;
  logic        rst_n_i, we_i, rx_i, tx_o;
  logic [31:0] addr_i, wr_data_i, do_o;

  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  logic chk_en = 1'b0;

  int         m_left = 0;
  logic [9:0] m_frame = 10'h3FF;
  logic [7:0] m_tx_buf = 8'h00;
  logic [7:0] m_rx_buf = 8'h00;
  logic       m_new_rx = 1'b0;
  rx_ent_t    rx_wave[$];
  rx_ev_t     ev_q[$];
  rx_ent_t    drv_e;
  rx_ev_t     mod_e;

  module_interfaz_uart #(.CLK_FREQ(1_000_000), .BAUD(100_000)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n_i),
    .we_i      (we_i),
    .addr_i    (addr_i),
    .wr_data_i (wr_data_i),
    .do_o      (do_o),
    .tx_o      (tx_o),
    .rx_i      (rx_i)
  );

  always #5 clk = ~clk;

  function automatic logic m_tx_exp();
    if (m_left > 0) return m_frame[(10 * DIV - m_left) / DIV];
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_do_exp(input logic [31:0] a);
    if (a[2]) return {24'h0, m_rx_buf};
    return {30'h0, m_new_rx, (m_left > 0)};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic fail_timeout(input string nm);
    n_chk++;
    $display("FAIL %s: timed out, got no completion, want completion (cycle %0d)", nm, cyc);
  endtask

  // Reference model: a frame is ten bits of DIV cycles counted down from a send.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n_i) begin
      m_left   = 0;
      m_tx_buf = 8'h00;
      m_rx_buf = 8'h00;
      m_new_rx = 1'b0;
      ev_q.delete();
    end else begin
      if (m_left > 0) m_left--;
      if (we_i && !addr_i[2]) begin
        if (wr_data_i[0] && m_left == 0) begin
          m_frame = {1'b1, m_tx_buf, 1'b0};
          m_left  = 10 * DIV;
        end
        if (!wr_data_i[1]) m_new_rx = 1'b0;
      end
      if (we_i && addr_i[2]) m_tx_buf = wr_data_i[7:0];
      if (ev_q.size() > 0 && ev_q[0].c == cyc) begin
        mod_e = ev_q.pop_front();
        if (mod_e.ok) begin
          m_new_rx = 1'b1;
          m_rx_buf = mod_e.b;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("tx_o", {31'd0, tx_o}, {31'd0, m_tx_exp()});
      check("do_o", do_o, m_do_exp(addr_i));
    end
  end

  // Serial line driver; announces the expected flag edge when a frame starts.
  initial begin
    rx_i = 1'b1;
    forever begin
      @(negedge clk);
      if (rx_wave.size() > 0) begin
        drv_e = rx_wave.pop_front();
        rx_i  = drv_e.lvl;
        if (drv_e.ev) ev_q.push_back('{c: cyc + RX_LAT, ok: drv_e.ok, b: drv_e.b});
      end else begin
        rx_i = 1'b1;
      end
    end
  end

  task automatic queue_frame(input logic [7:0] b, input logic stop_ok);
    logic [9:0] fr;
    fr = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < DIV; j++)
        rx_wave.push_back('{lvl: fr[i], ev: (i == 0 && j == 0), ok: stop_ok, b: b});
    for (int j = 0; j < 2 * DIV; j++)
      rx_wave.push_back('{lvl: 1'b1, ev: 1'b0, ok: 1'b0, b: 8'h00});
  endtask

  task automatic queue_glitch(input int len);
    for (int j = 0; j < len; j++) rx_wave.push_back('{lvl: 1'b0, ev: 1'b0, ok: 1'b0, b: 8'h00});
    for (int j = 0; j < 2 * DIV; j++) rx_wave.push_back('{lvl: 1'b1, ev: 1'b0, ok: 1'b0, b: 8'h00});
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr_i = a; wr_data_i = d; we_i = 1'b1;
    @(negedge clk);
    we_i = 1'b0;
  endtask

  task automatic wait_neg(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic read_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    addr_i = a;
    #1;
    check(nm, do_o, exp);
  endtask

  task automatic wait_rx_idle(input string nm);
    int k = 0;
    while ((rx_wave.size() > 0 || ev_q.size() > 0) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (rx_wave.size() > 0 || ev_q.size() > 0) fail_timeout(nm);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [9:0] a5_bits;
    int n0, tgt, k;
    logic did_reset;
    a5_bits   = 10'b1101001010;
    did_reset = 1'b0;
    rst_n_i = 1'b0; we_i = 1'b0; addr_i = A_CTRL; wr_data_i = 32'd0;

    repeat (3) @(negedge clk);
    check("reset tx_o", {31'd0, tx_o}, 32'd1);
    read_chk("reset ctrl", A_CTRL, 32'h0);
    read_chk("reset data", A_DATA, 32'h0);
    chk_en  = 1'b1;
    rst_n_i = 1'b1;
    @(negedge clk);

    // Single 0xA5 frame, sampled mid-bit.
    bus_write(A_DATA, 32'hA5);
    bus_write(A_CTRL, 32'h1);
    n0 = cyc;
    for (int i = 0; i < 10; i++) begin
      wait_neg(n0 + 10 * i + 5);
      check($sformatf("tx A5 bit%0d", i), {31'd0, tx_o}, {31'd0, a5_bits[i]});
      if (i == 5) read_chk("ctrl busy", A_CTRL, 32'h1);
    end
    wait_neg(n0 + 99);
    read_chk("ctrl last frame cycle", A_CTRL, 32'h1);
    wait_neg(n0 + 100);
    read_chk("ctrl after frame", A_CTRL, 32'h0);

    // Busy protection: new data and send during the frame.
    bus_write(A_DATA, 32'hA5);
    bus_write(A_CTRL, 32'h1);
    n0 = cyc;
    wait_neg(n0 + 29);
    bus_write(A_DATA, 32'h3C);
    bus_write(A_CTRL, 32'h1);
    wait_neg(n0 + 55);
    check("busy A5 bit4", {31'd0, tx_o}, 32'd0);
    wait_neg(n0 + 85);
    check("busy A5 bit7", {31'd0, tx_o}, 32'd1);
    wait_neg(n0 + 100);
    read_chk("busy send cleared", A_CTRL, 32'h0);
    wait_neg(n0 + 115);
    check("no second frame", {31'd0, tx_o}, 32'd1);
    bus_write(A_CTRL, 32'h1);
    n0 = cyc;
    wait_neg(n0 + 15);
    check("3C bit0", {31'd0, tx_o}, 32'd0);
    wait_neg(n0 + 35);
    check("3C bit2", {31'd0, tx_o}, 32'd1);
    wait_neg(n0 + 100);

    // Reset in the middle of a frame.
    bus_write(A_CTRL, 32'h1);
    repeat (37) @(negedge clk);
    rst_n_i = 1'b0;
    @(negedge clk);
    rst_n_i = 1'b1;
    check("mid-frame reset tx_o", {31'd0, tx_o}, 32'd1);
    read_chk("mid-frame reset ctrl", A_CTRL, 32'h0);

    // RX of 0x5A, then clear.
    queue_frame(8'h5A, 1'b1);
    wait_rx_idle("rx 5A");
    read_chk("rx ctrl new_rx", A_CTRL, 32'h2);
    read_chk("rx data 5A", A_DATA, 32'h5A);
    bus_write(A_CTRL, 32'h0);
    read_chk("rx ctrl cleared", A_CTRL, 32'h0);

    // Framing error and start-bit glitch.
    queue_frame(8'h77, 1'b0);
    wait_rx_idle("rx framing");
    read_chk("framing no flag", A_CTRL, 32'h0);
    read_chk("framing data kept", A_DATA, 32'h5A);
    queue_glitch(3);
    wait_rx_idle("rx glitch");
    read_chk("glitch no flag", A_CTRL, 32'h0);

    // Clear in the completion cycle of 0x11, then overrun with 0x22.
    queue_frame(8'h11, 1'b1);
    k = 0;
    while (ev_q.size() == 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (ev_q.size() == 0) begin
      fail_timeout("race start");
    end else begin
      tgt = ev_q[0].c;
      wait_neg(tgt - 1);
      bus_write(A_CTRL, 32'h0);
    end
    wait_rx_idle("rx 11");
    read_chk("race new_rx wins", A_CTRL, 32'h2);
    read_chk("race data 11", A_DATA, 32'h11);
    queue_frame(8'h22, 1'b1);
    wait_rx_idle("rx 22");
    read_chk("overrun new_rx", A_CTRL, 32'h2);
    read_chk("overrun data 22", A_DATA, 32'h22);

    // Randomized traffic on both directions.
    for (int it = 0; it < 3000; it++) begin
      int r;
      if (rx_wave.size() == 0 && $urandom_range(0, 39) == 0)
        queue_frame(8'($urandom), 1'($urandom_range(0, 7) != 0));
      r = $urandom_range(0, 99);
      if (r < 4) begin
        bus_write($urandom & 32'hFFFF_FFFB, {30'd0, 2'($urandom)});
      end else if (r < 8) begin
        bus_write($urandom | 32'h0000_0004, $urandom);
      end else if (r == 8 && it > 1500 && !did_reset && rx_wave.size() == 0 && ev_q.size() == 0) begin
        did_reset = 1'b1;
        rst_n_i = 1'b0;
        @(negedge clk);
        rst_n_i = 1'b1;
      end else begin
        addr_i = $urandom;
        @(negedge clk);
      end
    end
    wait_rx_idle("random rx drain");
    k = 0;
    while (m_left > 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (m_left > 0) fail_timeout("random tx drain");
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/module_interfaz_uart.md
# module_interfaz_uart

Memory-mapped UART peripheral occupying bus window 0x2020–0x2027, directly downstream of the bus conductor: it consumes `we_uart_o` as its write enable and returns read data on the conductor's `do_uart_i` input. It contains two registers (control/status and data), an 8N1 transmitter and an 8N1 receiver. The receiver uses a mid-bit sampling FSM. All logic runs on one clock domain; `rx_i` is the only asynchronous input.

## Interface
- `CLK_FREQ`, 10_000_000: system clock in Hz.
- `BAUD`, 9600: line rate.
- `DIV`, (CLK_FREQ + BAUD/2)/BAUD (local, 1042 at defaults): clock cycles per bit.

Ports:
- `clk_i`  in  1  system clock; all state updates on rising edge.
- `rst_n_i`  in  1  reset, synchronous, active-low.
- `we_i`  in  1  write enable from bus conductor (`we_uart_o`).
- `addr_i`  in  32  bus address; only bit 2 is decoded (0 = control at 0x2020, 1 = data at 0x2024).
- `wr_data_i`  in  32  processor write data.
- `do_o`  out  32  read data to bus conductor.
- `tx_o`  out  1  serial output, idle high.
- `rx_i`  in  1  serial input, asynchronous.

## Operation
- **Control register (0x2020):**
  - Bit0 `send`: a write of 1 while idle starts TX, and `send` reads 1 until the frame ends.
  - Bit1 `new_rx`: set by hardware on a valid received byte. A write of 0 clears it; a write of 1 is ignored.
  - Bits 31:2 read 0 and are not writable.
- **Data register (0x2024):**
  - Write: `wr_data_i[7:0]` goes to `tx_buf`.
  - Read: returns `{24'b0, rx_buf}`.
- **Read path:** `do_o` is combinational: `addr_i[2] ? data : control`.
- **TX FSM states:** `TX_IDLE`, `TX_START`, `TX_DATA`, `TX_STOP`.
  - A `send` write copies `tx_buf` into a shift register.
  - Bits go out LSB first, each lasting DIV cycles, with the bit index counting 0–7.
  - At the end of `TX_STOP` the FSM returns to `TX_IDLE` and `send` clears.
- **RX path:**
  - `rx_i` passes through a 2-FF synchronizer.
  - RX FSM states: `RX_IDLE`, `RX_START`, `RX_DATA`, `RX_STOP`.
  - A falling edge in `RX_IDLE` enters `RX_START`. The line is sampled at DIV/2; if it is high, this is a false start and the FSM returns to `RX_IDLE`.
  - Data bits are then sampled every DIV cycles, LSB first.
  - At the stop-bit sample: if high, `rx_buf` is loaded and `new_rx` is set; if low (framing error), the byte is discarded and flags are unchanged.
- **Boundary cases:**
  - Write `send`=1 while busy: ignored, and the current frame is unaffected.
  - Data write while busy: `tx_buf` updates; the frame in flight is unchanged.
  - Clearing `new_rx` in the same cycle that RX completes: set wins, so `new_rx` = 1.
  - Overrun (byte completes while `new_rx` = 1): `rx_buf` is overwritten and `new_rx` stays 1.
  - A control write with both bits affects each bit independently per the rules above.
  - Reset mid-frame: both FSMs return to IDLE, `tx_o` goes high the next cycle, and any partial byte is dropped.

## Timing
- **Reset values:**
  - `tx_o` = 1, `send` = 0, `new_rx` = 0, `tx_buf` = 0, `rx_buf` = 0.
  - Both FSMs in IDLE, all counters 0.
  - `do_o` then reads 0 at both addresses.
- **Register writes:** take effect on the edge where `we_i` = 1, and are visible on `do_o` the next cycle.
- **Reads:** zero-latency (combinational).
- **TX:**
  - With the `send` write at edge N, `tx_o` goes low after edge N.
  - The frame lasts exactly 10·DIV cycles.
  - `send` reads 0 from edge N + 10·DIV onward.
  - A new `send` accepted that same cycle gives back-to-back frames.
- **RX:**
  - Latency from the line falling edge to `new_rx` = 1 is 2 (synchronizer) + DIV/2 + 9·DIV cycles, ±1.
  - The bit-rate counter is 11 bits wide at defaults: `$clog2(DIV)`.

## Structure
- **Package `uart_pkg`:**
  - `tx_state_t` and `rx_state_t` enums.
  - Register offsets `CTRL_OFS` = 0, `DATA_OFS` = 4.
  - Bit positions `SEND_BIT` = 0, `NEW_RX_BIT` = 1.
- **Sub-module `uart_rx_core`:** the synchronizer, RX FSM and bit counter. It outputs `rx_byte[7:0]` and a one-cycle `rx_valid` pulse.
- **Top level:** the registers, read mux and TX FSM stay in the top module.

## Test plan
Bench parameters are CLK_FREQ = 1_000_000 and BAUD = 100_000, so DIV = 10.
- **Reset:** hold `rst_n_i` = 0 for 3 cycles → `tx_o` = 1; `do_o` = 0 at 0x2020 and at 0x2024.
- **TX frame:**
  - Write 0xA5 to 0x2024, then 1 to 0x2020.
  - `tx_o` gives start, then 1,0,1,0,0,1,0,1, then stop, each held 10 cycles.
  - Control reads 0x1 during the frame and 0x0 after 100 cycles.
- **Busy protection:** write 0x3C to data and `send` at cycle 30 of a 0xA5 frame → the 0xA5 frame completes unchanged, `send` clears at cycle 100, and no second frame starts.
- **RX:**
  - Drive 0x5A as 8N1 on `rx_i` → control reads 0x2 and data reads 0x5A.
  - Write 0 to control → control reads 0x0.
- **Framing error and glitch:**
  - Send a frame with the stop bit low → `new_rx` stays 0.
  - Drive a 3-cycle low glitch → the FSM returns to `RX_IDLE` with no flag.
- **Race and overrun:**
  - Clear `new_rx` in the completion cycle of a second byte 0x11 → `new_rx` = 1 and data reads 0x11.
  - Receive a third byte 0x22 without clearing → data reads 0x22.
